operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/register data width.
REQ-002 SHALL have parameter TAGW, default 32, meaning width of the opaque pass-through instruction tag.
REQ-003 SHALL have ports (reset i_rst, asynchronous, active-high; clock i_clk):
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_rs1, in_rs2, in_rd  in  5  source and destination register indices
- in_rd_wen  in  1  instruction writes in_rd
- in_tag  in  TAGW  pass-through payload
- rf_rs1, rf_rs2  out  5  register-file read addresses
- rf_rs1_val, rf_rs2_val  in  XLEN  register-file combinational read data
- wb_valid  in  1  writeback occurring this cycle (same cycle the register file is written)
- wb_rd  in  5  writeback destination
- wb_val  in  XLEN  writeback data
- out_valid  out  1  operands available
- out_ready  in  1  downstream consumes when out_valid && out_ready
- out_rs1_val, out_rs2_val  out  XLEN  resolved operands
- out_rd  out  5, out_rd_wen  out  1, out_tag  out  TAGW  registered copies of inputs

Function
REQ-004 SHALL drive rf_rs1 = in_rs1 and rf_rs2 = in_rs2 combinationally at all times.
REQ-005 SHALL keep a 32-bit pending scoreboard; pending[0] SHALL be constant 0.
REQ-006 SHALL resolve each source: index 0 -> 0; else wb_valid && wb_rd == index -> wb_val (bypass); else register-file value.
REQ-007 SHALL flag a hazard when in_valid and (rs1 != 0 and pending[rs1]) or (rs2 != 0 and pending[rs2]) or (in_rd_wen and in_rd != 0 and pending[in_rd]); a pending bit being cleared by wb in the same cycle SHALL NOT count as pending.
REQ-008 SHALL drive in_ready = (!out_valid || out_ready) && !hazard; in_ready MAY depend combinationally on in_* and wb_*.
REQ-009 On acceptance SHALL register resolved operands, in_rd, in_rd_wen and in_tag into out_* and set out_valid on the next edge (latency 1 cycle).
REQ-010 SHALL clear out_valid on an edge where out_valid && out_ready and nothing is accepted; consume and accept in the same cycle SHALL keep out_valid = 1 with new contents.
REQ-011 out_* SHALL hold stable while out_valid && !out_ready.
REQ-012 On acceptance with in_rd_wen && in_rd != 0, SHALL set pending[in_rd] at the next edge.
REQ-013 SHALL clear pending[wb_rd] at the edge of any cycle with wb_valid; when set and clear target the same index in one cycle, set SHALL win.
REQ-014 wb_valid for a non-pending index SHALL be ignored by the scoreboard (bypass in REQ-006 still applies).

Reset
REQ-015 i_rst SHALL asynchronously clear out_valid, all pending bits, out_rs1_val, out_rs2_val, out_rd, out_rd_wen, out_tag to 0.
REQ-016 Reset asserted mid-operation SHALL discard the held instruction; in_ready SHALL be 1 in the first cycle after release when no wb conflict exists.

Structure
REQ-017 SHALL take NUM_REGS (32), REG_ADDR_W (5) and XLEN from the shared package regfile_pkg.
REQ-018 SHALL place the scoreboard (set/clear/query, REQ-005/007/012-014) in sub-module reg_scoreboard.

Verification
REQ-019 Reset, then in rs1=3, rs2=0, rf_rs1_val=0x11 -> next cycle out_valid=1, out_rs1_val=0x11, out_rs2_val=0 (even if rf_rs2_val=0xFFFF_FFFF).
REQ-020 Accept rd=5 wen; next instr rs1=5 -> in_ready=0; then wb_valid rd=5 val=0xABCD -> same cycle in_ready=1, out_rs1_val=0xABCD next cycle, pending[5]=0.
REQ-021 out_ready=0 for 3 cycles with out_valid=1 -> out_* unchanged, in_ready=0; out_ready=1 with in_valid -> back-to-back issue, out_valid stays 1.
REQ-022 Accept rd=7 wen while wb_valid wb_rd=7 same cycle -> pending[7]=1 afterward.
REQ-023 Accept rd=0 wen -> no pending bit set; a following instruction with rs1=0 issues without stall and reads 0.
REQ-024 Assert i_rst while out_valid=1 and pending[9]=1 -> out_valid=0 and pending cleared immediately; instruction with rs1=9 accepted after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file parameters and index helpers.
package regfile_pkg;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  // One-hot mask for a register index.
  function automatic reg_mask_t idx_onehot(input reg_idx_t idx);
    return NUM_REGS'(1) << idx;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register.
// x0 is never pending. A writeback clearing a bit in the same cycle hides
// it from the hazard query; a same-cycle set of the same bit wins.
module reg_scoreboard
  import regfile_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  q_valid,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  input  logic [REG_ADDR_W-1:0] q_rd,
  input  logic                  q_rd_wen,
  input  logic                  set_en,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  output logic                  hazard
);

  reg_mask_t pending;
  reg_mask_t pending_eff;
  reg_mask_t pending_nxt;
  reg_mask_t clr_mask;
  reg_mask_t set_mask;

  // Masks for this cycle's clear and set, and the resulting next value.
  always_comb begin
    clr_mask    = clr_en ? idx_onehot(clr_idx) : '0;
    set_mask    = (set_en && q_rd != '0) ? idx_onehot(q_rd) : '0;
    pending_eff = pending & ~clr_mask;
    pending_nxt = pending_eff | set_mask;
    pending_nxt[0] = 1'b0;
  end

  // Hazard query against pending bits not being cleared this cycle.
  always_comb begin
    hazard = q_valid &&
             ((q_rs1 != '0 && pending_eff[q_rs1]) ||
              (q_rs2 != '0 && pending_eff[q_rs2]) ||
              (q_rd_wen && q_rd != '0 && pending_eff[q_rd]));
  end

  // Scoreboard state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) pending <= '0;
    else       pending <= pending_nxt;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, bypasses same-cycle
// writeback data, stalls on pending writes and holds one output slot.
module operand_fetch
  import regfile_pkg::*;
#(
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int TAGW = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic [TAGW-1:0]       in_tag,
  output logic [REG_ADDR_W-1:0] rf_rs1,
  output logic [REG_ADDR_W-1:0] rf_rs2,
  input  logic [XLEN-1:0]       rf_rs1_val,
  input  logic [XLEN-1:0]       rf_rs2_val,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_val,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_rs1_val,
  output logic [XLEN-1:0]       out_rs2_val,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_rd_wen,
  output logic [TAGW-1:0]       out_tag
);

  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] rs1_res;
  logic [XLEN-1:0] rs2_res;

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

  reg_scoreboard u_sb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .q_valid  (in_valid),
    .q_rs1    (in_rs1),
    .q_rs2    (in_rs2),
    .q_rd     (in_rd),
    .q_rd_wen (in_rd_wen),
    .set_en   (accept && in_rd_wen),
    .clr_en   (wb_valid),
    .clr_idx  (wb_rd),
    .hazard   (hazard)
  );

  // Operand resolution: x0, then writeback bypass, then register file.
  always_comb begin
    rs1_res = rf_rs1_val;
    rs2_res = rf_rs2_val;
    if (in_rs1 == '0)                       rs1_res = '0;
    else if (wb_valid && wb_rd == in_rs1)   rs1_res = wb_val;
    if (in_rs2 == '0)                       rs2_res = '0;
    else if (wb_valid && wb_rd == in_rs2)   rs2_res = wb_val;
  end

  // Handshake: slot free (or draining this cycle) and no pending hazard.
  always_comb begin
    in_ready = (!out_valid || out_ready) && !hazard;
    accept   = in_valid && in_ready;
  end

  // Output slot: load on accept, drop when consumed without refill.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_valid   <= 1'b0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_rd      <= '0;
      out_rd_wen  <= 1'b0;
      out_tag     <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_rs1_val <= rs1_res;
      out_rs2_val <= rs2_res;
      out_rd      <= in_rd;
      out_rd_wen  <= in_rd_wen;
      out_tag     <= in_tag;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a table of single-issue vectors
// followed by hand-written stall / backpressure / reset sequences.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        i_rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_wen;
  logic [31:0] in_tag;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rs1_val, rf_rs2_val;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [31:0] out_tag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .i_clk(clk), .i_rst(i_rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rd_wen(in_rd_wen), .in_tag(in_tag),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_val(wb_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_tag(out_tag)
  );

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        wen;
    logic [31:0] tag, rf1, rf2;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbval;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen, input logic [31:0] tag,
                       input logic [31:0] rf1, input logic [31:0] rf2);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_wen = wen;
    in_tag = tag; rf_rs1_val = rf1; rf_rs2_val = rf2;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] val);
    wb_valid = v; wb_rd = rd; wb_val = val;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{rs1:3,  rs2:0,  rd:1, wen:0, tag:32'h100, rf1:32'h11,   rf2:32'hFFFF_FFFF,
                wbv:0, wbrd:0,  wbval:0,          e1:32'h11,   e2:32'h0};
    vecs[1] = '{rs1:4,  rs2:6,  rd:2, wen:0, tag:32'h101, rf1:32'hAAAA, rf2:32'hBBBB,
                wbv:1, wbrd:6,  wbval:32'h1234,   e1:32'hAAAA, e2:32'h1234};
    vecs[2] = '{rs1:8,  rs2:8,  rd:3, wen:0, tag:32'h102, rf1:32'h5,    rf2:32'h5,
                wbv:1, wbrd:8,  wbval:32'h77,     e1:32'h77,   e2:32'h77};
    vecs[3] = '{rs1:0,  rs2:0,  rd:0, wen:1, tag:32'h103, rf1:32'h9,    rf2:32'h9,
                wbv:1, wbrd:0,  wbval:32'hDEAD,   e1:32'h0,    e2:32'h0};
    vecs[4] = '{rs1:31, rs2:1,  rd:4, wen:0, tag:32'h104, rf1:32'h3131, rf2:32'h0101,
                wbv:1, wbrd:2,  wbval:32'h2222,   e1:32'h3131, e2:32'h0101};
    vecs[5] = '{rs1:10, rs2:11, rd:5, wen:0, tag:32'h105, rf1:32'h1010, rf2:32'h1111,
                wbv:0, wbrd:10, wbval:32'h999,    e1:32'h1010, e2:32'h1111};

    i_rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rs1", out_rs1_val, 0);
    chk("rst_out_tag", out_tag, 0);
    i_rst = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      drive(1, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wen, vecs[i].tag,
            vecs[i].rf1, vecs[i].rf2);
      wb(vecs[i].wbv, vecs[i].wbrd, vecs[i].wbval);
      out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      chk($sformatf("v%0d_rf_rs1", i), rf_rs1, vecs[i].rs1);
      chk($sformatf("v%0d_rf_rs2", i), rf_rs2, vecs[i].rs2);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      wb(0, 0, 0);
      #1;
      chk($sformatf("v%0d_out_valid", i), out_valid, 1);
      chk($sformatf("v%0d_out_rs1", i), out_rs1_val, vecs[i].e1);
      chk($sformatf("v%0d_out_rs2", i), out_rs2_val, vecs[i].e2);
      chk($sformatf("v%0d_out_rd", i), out_rd, vecs[i].rd);
      chk($sformatf("v%0d_out_wen", i), out_rd_wen, vecs[i].wen);
      chk($sformatf("v%0d_out_tag", i), out_tag, vecs[i].tag);
      step();
      chk($sformatf("v%0d_drain", i), out_valid, 0);
    end

    // RAW stall on rd=5, released by same-cycle writeback with bypass.
    drive(1, 0, 0, 5, 1, 32'h20, 0, 0);
    #1 chk("raw_first_ready", in_ready, 1);
    step();
    chk("raw_first_valid", out_valid, 1);
    drive(1, 5, 0, 0, 0, 32'h21, 32'h1111, 0);
    #1 chk("raw_stall", in_ready, 0);
    step();
    chk("raw_consumed", out_valid, 0);
    wb(1, 5, 32'hABCD);
    #1 chk("raw_wb_release", in_ready, 1);
    step();
    wb(0, 0, 0);
    chk("raw_out_valid", out_valid, 1);
    chk("raw_bypass_val", out_rs1_val, 32'hABCD);
    chk("raw_tag", out_tag, 32'h21);

    // Backpressure: output held, input stalled, then back-to-back issue.
    out_ready = 1'b0;
    drive(1, 2, 3, 0, 0, 32'h22, 32'h2222, 32'h3333);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", c), in_ready, 0);
      chk($sformatf("bp%0d_valid", c), out_valid, 1);
      chk($sformatf("bp%0d_rs1", c), out_rs1_val, 32'hABCD);
      chk($sformatf("bp%0d_tag", c), out_tag, 32'h21);
      step();
    end
    out_ready = 1'b1;
    #1 chk("b2b_in_ready", in_ready, 1);
    step();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_rs1", out_rs1_val, 32'h2222);
    chk("b2b_rs2", out_rs2_val, 32'h3333);
    chk("b2b_tag", out_tag, 32'h22);
    drive(1, 5, 0, 0, 0, 32'h23, 32'h5555, 0);
    #1 chk("pend5_cleared", in_ready, 1);
    step();
    chk("pend5_rs1", out_rs1_val, 32'h5555);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("bp_drain", out_valid, 0);

    // Set and clear of rd=7 in one cycle: set wins.
    drive(1, 0, 0, 7, 1, 32'h24, 0, 0);
    wb(1, 7, 32'h0);
    #1 chk("sw_accept", in_ready, 1);
    step();
    wb(0, 0, 0);
    drive(1, 7, 0, 0, 0, 32'h25, 0, 0);
    #1 chk("sw_raw_stall", in_ready, 0);
    drive(1, 0, 0, 7, 1, 32'h26, 0, 0);
    #1 chk("sw_waw_stall", in_ready, 0);
    wb(1, 7, 32'h5);
    #1 chk("sw_waw_release", in_ready, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 7, 32'h6);
    step();
    wb(0, 0, 0);
    step();

    // rd=0 with write enable never becomes pending; x0 reads as zero.
    drive(1, 0, 0, 0, 1, 32'h27, 0, 0);
    step();
    drive(1, 0, 0, 0, 1, 32'h28, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1 chk("x0_no_stall", in_ready, 1);
    step();
    chk("x0_rs1_zero", out_rs1_val, 0);
    chk("x0_tag", out_tag, 32'h28);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Reset mid-operation with out_valid=1 and rd=9 pending.
    drive(1, 0, 0, 9, 1, 32'h29, 0, 0);
    step();
    chk("rst9_valid_before", out_valid, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("rst9_out_valid", out_valid, 0);
    chk("rst9_out_tag", out_tag, 0);
    chk("rst9_out_rd", out_rd, 0);
    chk("rst9_out_wen", out_rd_wen, 0);
    @(negedge clk);
    i_rst = 1'b0;
    drive(1, 9, 0, 0, 0, 32'h2A, 32'h9999, 0);
    #1 chk("rst9_in_ready", in_ready, 1);
    step();
    chk("rst9_accepted", out_valid, 1);
    chk("rst9_rs1", out_rs1_val, 32'h9999);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
